memory_bus_initiator: RTL and testbench

CPU-side initiator for the memory bus: takes one load/store at a time from a core, issues it as a `bus_write_data` or `bus_read_data` packet toward the DRAM responder, and returns completion to the core. For reads it waits for the responder's read response addressed to its own source id. It enforces the responder's address bound, applies a response timeout, and counts stray responses.

---
 rtl/memory_bus_initiator_pkg.sv | 30 +++
 rtl/memory_bus_initiator_if.sv | 49 ++++
 rtl/memory_bus_initiator_timer.sv | 40 ++++
 rtl/memory_bus_initiator.sv | 146 ++++++++++++++
 tb/tb_memory_bus_initiator.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_bus_initiator_pkg.sv
// rtl/memory_bus_initiator_pkg.sv - shared types and constants for the memory bus initiator
package memory_bus_initiator_pkg;

    localparam int DEFAULT_MEM_BYTES = 65536;
    localparam int DEFAULT_ADDR_W    = 32;
    localparam int PAYLOAD_W         = 64;
    localparam int STRAY_W           = 16;

    // Packet kinds understood by the DRAM responder.
    typedef enum logic {
        bus_read_data  = 1'b0,
        bus_write_data = 1'b1
    } bus_packet_type_t;

    typedef logic [PAYLOAD_W-1:0]      bus_packet_payload_t;
    typedef logic [DEFAULT_ADDR_W-1:0] phys_memory_address_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_RESPOND   = 2'd3
    } init_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STRAY_W-1:0] sat_inc(input logic [STRAY_W-1:0] v);
        return (v == {STRAY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/memory_bus_initiator_if.sv
// rtl/memory_bus_initiator_if.sv - core-side and bus-side handshake bundle of the initiator
interface memory_bus_initiator_if #(
    parameter int SRC_W  = 4,
    parameter int ADDR_W = 32
);
    import memory_bus_initiator_pkg::*;

    // Core request / completion
    logic                cpu_req_valid;
    logic                cpu_req_ready;
    logic                cpu_req_write;
    logic [ADDR_W-1:0]   cpu_req_addr;
    bus_packet_payload_t cpu_req_wdata;
    logic                cpu_rsp_valid;
    bus_packet_payload_t cpu_rsp_rdata;
    logic                cpu_rsp_error;

    // Bus request toward the responder
    logic                bus_req_valid;
    logic                bus_req_accept;
    bus_packet_type_t    bus_req_type;
    logic [ADDR_W-1:0]   bus_req_address;
    bus_packet_payload_t bus_req_payload;
    logic [SRC_W-1:0]    bus_req_source;

    // Bus read response
    logic                bus_rsp_valid;
    bus_packet_payload_t bus_rsp_payload;
    logic [SRC_W-1:0]    bus_rsp_dest;

    // The initiator itself
    modport master (
        input  cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_error,
        output bus_req_valid, bus_req_type, bus_req_address, bus_req_payload, bus_req_source,
        input  bus_req_accept,
        input  bus_rsp_valid, bus_rsp_payload, bus_rsp_dest
    );

    // The environment around it (core plus responder)
    modport slave (
        output cpu_req_valid, cpu_req_write, cpu_req_addr, cpu_req_wdata,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_error,
        input  bus_req_valid, bus_req_type, bus_req_address, bus_req_payload, bus_req_source,
        output bus_req_accept,
        output bus_rsp_valid, bus_rsp_payload, bus_rsp_dest
    );

endinterface

// File: rtl/memory_bus_initiator_timer.sv
// rtl/memory_bus_initiator_timer.sv - read-response timeout counter
module bus_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count enabled cycles, holding at the last value so it cannot wrap into a false restart.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Expiry is the final enabled cycle of the window, so the caller sees it in the same cycle.
    assign expired = enable && (count_q == LAST);

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_bus_initiator.sv
// rtl/memory_bus_initiator.sv - single-outstanding load/store initiator for the memory bus
module memory_bus_initiator
    import memory_bus_initiator_pkg::*;
#(
    parameter int MY_ID          = 0,
    parameter int SRC_W          = 4,
    parameter int ADDR_W         = 32,
    parameter int MEM_BYTES      = DEFAULT_MEM_BYTES,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    memory_bus_initiator_if.master bus_if,
    output logic [STRAY_W-1:0]  stray_count
);

    // Highest address whose 8-byte access still fits in the responder.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);
    localparam logic [SRC_W-1:0]  ID       = SRC_W'(MY_ID);

    init_state_t         state_q, state_d;
    bus_packet_type_t    type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    bus_packet_payload_t wdata_q, wdata_d;
    bus_packet_payload_t rdata_q, rdata_d;
    logic                error_q, error_d;
    logic [STRAY_W-1:0]  stray_count_q, stray_count_d;
    logic                alive_q, alive_d;

    logic rsp_match;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign rsp_match    = bus_if.bus_rsp_valid && (bus_if.bus_rsp_dest == ID);
    assign timer_clear  = (state_q != ST_WAIT_RESP);
    assign timer_enable = (state_q == ST_WAIT_RESP);

    bus_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // Next-state and datapath capture for the transaction FSM, plus the stray-response counter.
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        error_d       = error_q;
        stray_count_d = stray_count_q;
        alive_d       = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus_if.cpu_req_valid && alive_q) begin
                    type_d  = bus_if.cpu_req_write ? bus_write_data : bus_read_data;
                    addr_d  = bus_if.cpu_req_addr;
                    wdata_d = bus_if.cpu_req_write ? bus_if.cpu_req_wdata : '0;
                    rdata_d = '0;
                    if (bus_if.cpu_req_addr > MAX_ADDR) begin
                        // Rejected locally; the responder never sees it.
                        error_d = 1'b1;
                        state_d = ST_RESPOND;
                    end else begin
                        error_d = 1'b0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (bus_if.bus_req_accept) begin
                    state_d = (type_q == bus_write_data) ? ST_RESPOND : ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                // A response arriving on the expiry cycle still counts as a success.
                if (rsp_match) begin
                    rdata_d = bus_if.bus_rsp_payload;
                    error_d = 1'b0;
                    state_d = ST_RESPOND;
                end else if (timer_expired) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Our responses outside the wait window (including late ones after a timeout) are dropped.
        if (rsp_match && (state_q != ST_WAIT_RESP)) begin
            stray_count_d = sat_inc(stray_count_q);
        end
    end

    // State and captured transaction registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            type_q        <= bus_read_data;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            error_q       <= 1'b0;
            stray_count_q <= '0;
            alive_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
            stray_count_q <= stray_count_d;
            alive_q       <= alive_d;
        end
    end

    // alive_q keeps ready low during reset and lets it rise on the first cycle after release.
    assign bus_if.cpu_req_ready   = alive_q && (state_q == ST_IDLE);
    assign bus_if.cpu_rsp_valid   = (state_q == ST_RESPOND);
    assign bus_if.cpu_rsp_rdata   = (state_q == ST_RESPOND) ? rdata_q : '0;
    assign bus_if.cpu_rsp_error   = (state_q == ST_RESPOND) && error_q;

    // Request fields are only presented while the request is pending, and hold steady until accepted.
    assign bus_if.bus_req_valid   = (state_q == ST_SEND);
    assign bus_if.bus_req_type    = (state_q == ST_SEND) ? type_q : bus_read_data;
    assign bus_if.bus_req_address = (state_q == ST_SEND) ? addr_q : '0;
    assign bus_if.bus_req_payload = (state_q == ST_SEND) ? wdata_q : '0;
    assign bus_if.bus_req_source  = ID;

    assign stray_count = stray_count_q;

endmodule

// File: tb/tb_memory_bus_initiator.sv
// tb/tb_memory_bus_initiator.sv - directed testbench for memory_bus_initiator
module tb_memory_bus_initiator;
    import memory_bus_initiator_pkg::*;

    localparam int MY_ID  = 5;
    localparam int SRC_W  = 4;
    localparam int ADDR_W = 32;
    localparam int MEM    = 65536;
    localparam int TO     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] stray_count;
    int          tests_run = 0;
    int          tests_failed = 0;

    memory_bus_initiator_if #(.SRC_W(SRC_W), .ADDR_W(ADDR_W)) bif ();

    memory_bus_initiator #(
        .MY_ID(MY_ID), .SRC_W(SRC_W), .ADDR_W(ADDR_W),
        .MEM_BYTES(MEM), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_if      (bif.master),
        .stray_count (stray_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.cpu_req_valid   = 1'b0;
        bif.cpu_req_write   = 1'b0;
        bif.cpu_req_addr    = '0;
        bif.cpu_req_wdata   = '0;
        bif.bus_req_accept  = 1'b0;
        bif.bus_rsp_valid   = 1'b0;
        bif.bus_rsp_payload = '0;
        bif.bus_rsp_dest    = '0;
    endtask

    // Present a request for one cycle (cycle 0) and return at cycle 1.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [63:0] d);
        bif.cpu_req_valid = 1'b1;
        bif.cpu_req_write = wr;
        bif.cpu_req_addr  = a;
        bif.cpu_req_wdata = d;
        step();
        bif.cpu_req_valid = 1'b0;
        bif.cpu_req_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if (bif.cpu_req_ready !== 1'b0 || bif.cpu_rsp_valid !== 1'b0 || bif.bus_req_valid !== 1'b0 ||
            stray_count !== 16'd0 || bif.cpu_rsp_rdata !== 64'd0 || bif.cpu_rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b req_valid=%b stray=%0d expected all 0",
                     bif.cpu_req_ready, bif.cpu_rsp_valid, bif.bus_req_valid, stray_count);
        end
        rst_n = 1'b1;
        tests_run++;
        if (bif.cpu_req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 0", bif.cpu_req_ready);
        end
        step();
        tests_run++;
        if (bif.cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b expected 1", bif.cpu_req_ready);
        end
    endtask

    task automatic test_store();
        issue(1'b1, 32'h100, 64'h1122334455667788);
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (bif.bus_req_valid !== 1'b1 || bif.bus_req_type !== bus_write_data ||
                bif.bus_req_address !== 32'h100 || bif.bus_req_payload !== 64'h1122334455667788 ||
                bif.bus_req_source !== 4'd5 || bif.cpu_rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL store_hold_%0d: valid=%b type=%0d addr=%h payload=%h src=%0d expected 1/1/100/1122334455667788/5",
                         k, bif.bus_req_valid, bif.bus_req_type, bif.bus_req_address, bif.bus_req_payload, bif.bus_req_source);
            end
            step();
        end
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept = 1'b0;
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0 || bif.cpu_rsp_rdata !== 64'd0 ||
            bif.bus_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_rsp: valid=%b err=%b rdata=%h req_valid=%b expected 1/0/0/0",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata, bif.bus_req_valid);
        end
        step();
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b0 || bif.cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_single_pulse: rsp_valid=%b ready=%b expected 0/1", bif.cpu_rsp_valid, bif.cpu_req_ready);
        end
    endtask

    task automatic test_load();
        logic seen_early;
        seen_early = 1'b0;
        issue(1'b0, 32'h100, 64'h0);
        tests_run++;
        if (bif.bus_req_valid !== 1'b1 || bif.bus_req_type !== bus_read_data ||
            bif.bus_req_address !== 32'h100 || bif.bus_req_payload !== 64'd0) begin
            tests_failed++;
            $display("FAIL load_req: valid=%b type=%0d addr=%h payload=%h expected 1/0/100/0",
                     bif.bus_req_valid, bif.bus_req_type, bif.bus_req_address, bif.bus_req_payload);
        end
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bif.cpu_rsp_valid !== 1'b0) seen_early = 1'b1;
            step();
        end
        bif.bus_rsp_valid   = 1'b1;
        bif.bus_rsp_dest    = 4'd5;
        bif.bus_rsp_payload = 64'hDEADBEEFCAFEF00D;
        step();
        bif.bus_rsp_valid = 1'b0;
        tests_run++;
        if (seen_early !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_early_rsp: got %b expected 0", seen_early);
        end
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0 || bif.cpu_rsp_rdata !== 64'hDEADBEEFCAFEF00D) begin
            tests_failed++;
            $display("FAIL load_rsp: valid=%b err=%b rdata=%h expected 1/0/deadbeefcafef00d",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata);
        end
        step();
    endtask

    task automatic test_wrong_dest();
        issue(1'b0, 32'h200, 64'h0);
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept  = 1'b0;
        bif.bus_rsp_valid   = 1'b1;
        bif.bus_rsp_dest    = 4'd2;
        bif.bus_rsp_payload = 64'h5555AAAA5555AAAA;
        step();
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b0 || stray_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL wrong_dest_ignored: rsp_valid=%b stray=%0d expected 0/0", bif.cpu_rsp_valid, stray_count);
        end
        bif.bus_rsp_dest    = 4'd5;
        bif.bus_rsp_payload = 64'h0123456789ABCDEF;
        step();
        bif.bus_rsp_valid = 1'b0;
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_rdata !== 64'h0123456789ABCDEF || stray_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL wrong_dest_then_match: valid=%b rdata=%h stray=%0d expected 1/0123456789abcdef/0",
                     bif.cpu_rsp_valid, bif.cpu_rsp_rdata, stray_count);
        end
        step();
    endtask

    task automatic test_bounds();
        issue(1'b0, 32'(MEM - 7), 64'h0);
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b1 || bif.cpu_rsp_rdata !== 64'd0 ||
            bif.bus_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bound_over: valid=%b err=%b rdata=%h req_valid=%b expected 1/1/0/0",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata, bif.bus_req_valid);
        end
        step();
        tests_run++;
        if (bif.bus_req_valid !== 1'b0 || bif.cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bound_over_after: req_valid=%b ready=%b expected 0/1", bif.bus_req_valid, bif.cpu_req_ready);
        end
        issue(1'b0, 32'(MEM - 8), 64'h0);
        tests_run++;
        if (bif.bus_req_valid !== 1'b1 || bif.bus_req_address !== 32'h0000FFF8 || bif.cpu_rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bound_edge_req: req_valid=%b addr=%h rsp_valid=%b expected 1/0000fff8/0",
                     bif.bus_req_valid, bif.bus_req_address, bif.cpu_rsp_valid);
        end
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept  = 1'b0;
        bif.bus_rsp_valid   = 1'b1;
        bif.bus_rsp_dest    = 4'd5;
        bif.bus_rsp_payload = 64'hFEEDFACE00000001;
        step();
        bif.bus_rsp_valid = 1'b0;
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0 || bif.cpu_rsp_rdata !== 64'hFEEDFACE00000001) begin
            tests_failed++;
            $display("FAIL bound_edge_rsp: valid=%b err=%b rdata=%h expected 1/0/feedface00000001",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        logic seen_early;
        seen_early = 1'b0;
        issue(1'b0, 32'h300, 64'h0);
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (bif.cpu_rsp_valid !== 1'b0) seen_early = 1'b1;
            step();
        end
        tests_run++;
        if (seen_early !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: got %b expected 0", seen_early);
        end
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b1 || bif.cpu_rsp_rdata !== 64'd0) begin
            tests_failed++;
            $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h expected 1/1/0",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata);
        end
        step();
        bif.bus_rsp_valid   = 1'b1;
        bif.bus_rsp_dest    = 4'd5;
        bif.bus_rsp_payload = 64'h1;
        step();
        bif.bus_rsp_valid = 1'b0;
        tests_run++;
        if (stray_count !== 16'd1 || bif.cpu_rsp_valid !== 1'b0 || bif.bus_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_stray: stray=%0d rsp_valid=%b req_valid=%b expected 1/0/0",
                     stray_count, bif.cpu_rsp_valid, bif.bus_req_valid);
        end
    endtask

    task automatic test_expiry_race();
        issue(1'b0, 32'h308, 64'h0);
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept = 1'b0;
        for (int k = 0; k < TO - 1; k++) step();
        bif.bus_rsp_valid   = 1'b1;
        bif.bus_rsp_dest    = 4'd5;
        bif.bus_rsp_payload = 64'hA5A5A5A5_5A5A5A5A;
        step();
        bif.bus_rsp_valid = 1'b0;
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0 ||
            bif.cpu_rsp_rdata !== 64'hA5A5A5A5_5A5A5A5A || stray_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL expiry_race: valid=%b err=%b rdata=%h stray=%0d expected 1/0/a5a5a5a55a5a5a5a/1",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata, stray_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bif.bus_req_accept = 1'b1;
        issue(1'b1, 32'h100, 64'h0000000000000011);
        step();
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first_rsp: valid=%b err=%b expected 1/0", bif.cpu_rsp_valid, bif.cpu_rsp_error);
        end
        step();
        tests_run++;
        if (bif.cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready: got %b expected 1", bif.cpu_req_ready);
        end
        issue(1'b1, 32'h108, 64'h0000000000000022);
        tests_run++;
        if (bif.bus_req_valid !== 1'b1 || bif.bus_req_address !== 32'h108 || bif.bus_req_payload !== 64'h22) begin
            tests_failed++;
            $display("FAIL b2b_second_req: valid=%b addr=%h payload=%h expected 1/108/22",
                     bif.bus_req_valid, bif.bus_req_address, bif.bus_req_payload);
        end
        step();
        bif.bus_req_accept = 1'b0;
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_rsp: valid=%b err=%b expected 1/0", bif.cpu_rsp_valid, bif.cpu_rsp_error);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h40, 64'h0);
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bif.cpu_req_ready !== 1'b0 || bif.cpu_rsp_valid !== 1'b0 || bif.bus_req_valid !== 1'b0 ||
            stray_count !== 16'd0 || bif.cpu_rsp_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: ready=%b rsp_valid=%b req_valid=%b stray=%0d err=%b expected all 0",
                     bif.cpu_req_ready, bif.cpu_rsp_valid, bif.bus_req_valid, stray_count, bif.cpu_rsp_error);
        end
        step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b0 || bif.cpu_req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_no_pulse: rsp_valid=%b ready=%b expected 0/1", bif.cpu_rsp_valid, bif.cpu_req_ready);
        end
        issue(1'b0, 32'h40, 64'h0);
        bif.bus_req_accept = 1'b1;
        step();
        bif.bus_req_accept  = 1'b0;
        bif.bus_rsp_valid   = 1'b1;
        bif.bus_rsp_dest    = 4'd5;
        bif.bus_rsp_payload = 64'h0BADC0DE12345678;
        step();
        bif.bus_rsp_valid = 1'b0;
        tests_run++;
        if (bif.cpu_rsp_valid !== 1'b1 || bif.cpu_rsp_error !== 1'b0 || bif.cpu_rsp_rdata !== 64'h0BADC0DE12345678) begin
            tests_failed++;
            $display("FAIL reset_mid_next_load: valid=%b err=%b rdata=%h expected 1/0/0badc0de12345678",
                     bif.cpu_rsp_valid, bif.cpu_rsp_error, bif.cpu_rsp_rdata);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_wrong_dest();
        test_bounds();
        test_timeout();
        test_expiry_race();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
